// File: rtl/aes_avalon_interface.sv
// aes_avalon_interface
// Avalon-MM register front end for the AES decryption core. Software loads
// key (REG0-3) and ciphertext (REG4-7), sets REG14 bit0 to start, and reads
// the captured plaintext (REG8-11) and STATUS (REG15: bit0 DONE, bit1 BUSY).
//
// Ports:
//   CLK, RESET_N        clock, async active-low reset
//   AVL_CS/READ/WRITE   slave strobes
//   AVL_ADDR            16 x 32-bit word address
//   AVL_BYTE_EN         per-byte write enables
//   AVL_WRITEDATA       write data
//   AVL_READDATA        registered read data, 1-cycle latency
//   EXPORT_DATA         {REG4[31:16], REG7[15:0]} for hex displays
//   AES_START           registered start/hold request to the core
//   AES_DONE            core done, held high while AES_START is high
//   AES_KEY             {REG0..REG3}
//   AES_MSG_ENC         {REG4..REG7}
//   AES_MSG_DEC         core plaintext, valid while AES_DONE=1
//
// state    | meaning
// IDLE     | no operation; AES_START=0, BUSY=0
// RUN      | core working; AES_START=1, BUSY=1, key/ciphertext locked
// COMPLETE | plaintext captured; AES_START held until software writes 0
// ABORT    | software cancelled; waiting for the core to finish, result dropped

module aes_avalon_interface (
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic         AVL_CS,
  input  logic         AVL_READ,
  input  logic         AVL_WRITE,
  input  logic [3:0]   AVL_ADDR,
  input  logic [3:0]   AVL_BYTE_EN,
  input  logic [31:0]  AVL_WRITEDATA,
  output logic [31:0]  AVL_READDATA,
  output logic [31:0]  EXPORT_DATA,
  output logic         AES_START,
  input  logic         AES_DONE,
  output logic [127:0] AES_KEY,
  output logic [127:0] AES_MSG_ENC,
  input  logic [127:0] AES_MSG_DEC
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_COMPLETE, S_ABORT} state_t;

  state_t      state;
  logic [31:0] regs [14];
  logic        done_flag;
  logic        busy;
  logic        wr_en;
  logic        start_wr;
  logic        go_wr;
  logic        stop_wr;
  logic        capture;
  logic [31:0] rd_mux;

  assign busy     = (state == S_RUN) || (state == S_ABORT);
  assign wr_en    = AVL_CS & AVL_WRITE;
  assign start_wr = wr_en && (AVL_ADDR == 4'd14) && AVL_BYTE_EN[0];
  assign go_wr    = start_wr &  AVL_WRITEDATA[0];
  assign stop_wr  = start_wr & ~AVL_WRITEDATA[0];
  // A stop request in the same cycle as done wins: the result is discarded.
  assign capture  = (state == S_RUN) && AES_DONE && !stop_wr;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++)
      if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
    return res;
  endfunction

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= S_IDLE;
      AES_START <= 1'b0;
      done_flag <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (go_wr) begin
          state     <= S_RUN;
          AES_START <= 1'b1;
          done_flag <= 1'b0;
        end
        S_RUN: begin
          if (stop_wr) begin
            AES_START <= 1'b0;
            state     <= AES_DONE ? S_IDLE : S_ABORT;
          end else if (AES_DONE) begin
            state     <= S_COMPLETE;
            done_flag <= 1'b1;
          end
        end
        S_COMPLETE: if (stop_wr) begin
          state     <= S_IDLE;
          AES_START <= 1'b0;
        end
        S_ABORT: if (AES_DONE) state <= S_IDLE;
        default: begin
          state     <= S_IDLE;
          AES_START <= 1'b0;
        end
      endcase
    end
  end

  // Key/ciphertext are locked while the core may be sampling them; the
  // plaintext words are only ever loaded by capture.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < 14; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < 14; i++) begin
        if (wr_en && (AVL_ADDR == 4'(i)) &&
            (((i < 8) && !busy) || (i == 12) || (i == 13)))
          regs[i] <= merge_bytes(regs[i], AVL_WRITEDATA, AVL_BYTE_EN);
      end
      if (capture) begin
        regs[8]  <= AES_MSG_DEC[127:96];
        regs[9]  <= AES_MSG_DEC[95:64];
        regs[10] <= AES_MSG_DEC[63:32];
        regs[11] <= AES_MSG_DEC[31:0];
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    if (AVL_ADDR == 4'd14)      rd_mux = {31'b0, AES_START};
    else if (AVL_ADDR == 4'd15) rd_mux = {30'b0, busy, done_flag};
    else                        rd_mux = regs[AVL_ADDR];
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)                AVL_READDATA <= '0;
    else if (AVL_CS & AVL_READ)  AVL_READDATA <= rd_mux;
  end

  assign AES_KEY     = {regs[0], regs[1], regs[2], regs[3]};
  assign AES_MSG_ENC = {regs[4], regs[5], regs[6], regs[7]};
  assign EXPORT_DATA = {regs[4][31:16], regs[7][15:0]};

endmodule

// File: tb/tb_aes_avalon_interface.sv
// Testbench for aes_avalon_interface. The AES core is a stub driven directly
// by the stimulus (AES_DONE / AES_MSG_DEC). A reference model holds the
// register map as a plain array and the operation phase as (start, busy).

module tb_aes_avalon_interface;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cs = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [3:0]   addr = '0, be = '0;
  logic [31:0]  wdata = '0;
  logic [31:0]  readdata, export_data;
  logic         aes_start;
  logic         aes_done = 1'b0;
  logic [127:0] aes_key, aes_msg_enc;
  logic [127:0] msg_dec = '0;

  int checks = 0;
  int errors = 0;

  // reference model
  logic [31:0] mem [16];
  logic        exp_start, exp_busy, exp_done;
  logic [31:0] exp_rd;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;

  aes_avalon_interface dut (
    .CLK(clk), .RESET_N(rst_n), .AVL_CS(cs), .AVL_READ(rd), .AVL_WRITE(wr),
    .AVL_ADDR(addr), .AVL_BYTE_EN(be), .AVL_WRITEDATA(wdata),
    .AVL_READDATA(readdata), .EXPORT_DATA(export_data), .AES_START(aes_start),
    .AES_DONE(aes_done), .AES_KEY(aes_key), .AES_MSG_ENC(aes_msg_enc),
    .AES_MSG_DEC(msg_dec)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [3:0] a);
    if (a == 4'd14) return {31'b0, exp_start};
    if (a == 4'd15) return {30'b0, exp_busy, exp_done};
    return mem[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mem[i] = '0;
    exp_start = 1'b0; exp_busy = 1'b0; exp_done = 1'b0; exp_rd = '0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_start"},  128'(aes_start), 128'(exp_start));
    chk({tag, "_key"},    aes_key,     {mem[0], mem[1], mem[2], mem[3]});
    chk({tag, "_enc"},    aes_msg_enc, {mem[4], mem[5], mem[6], mem[7]});
    chk({tag, "_export"}, 128'(export_data), 128'({mem[4][31:16], mem[7][15:0]}));
    chk({tag, "_rdata"},  128'(readdata), 128'(exp_rd));
  endtask

  // One clock: update the model from the inputs as they stand before the edge.
  task automatic tick();
    logic is_wr, stop_req, go_req;
    is_wr    = cs && wr;
    go_req   = is_wr && addr == 4'd14 && be[0] && wdata[0];
    stop_req = is_wr && addr == 4'd14 && be[0] && !wdata[0];
    if (cs && rd) exp_rd = model_read(addr);
    if (is_wr && ((addr < 4'd8 && !exp_busy) || addr == 4'd12 || addr == 4'd13))
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[addr][8*b +: 8] = wdata[8*b +: 8];
    if (!exp_start && !exp_busy) begin
      if (go_req) begin exp_start = 1'b1; exp_busy = 1'b1; exp_done = 1'b0; end
    end else if (exp_start && exp_busy) begin
      if (stop_req) begin
        exp_start = 1'b0;
        exp_busy  = !aes_done;
      end else if (aes_done) begin
        mem[8] = msg_dec[127:96]; mem[9]  = msg_dec[95:64];
        mem[10] = msg_dec[63:32]; mem[11] = msg_dec[31:0];
        exp_done = 1'b1; exp_busy = 1'b0;
      end
    end else if (exp_start) begin
      if (stop_req) exp_start = 1'b0;
    end else begin
      if (aes_done) exp_busy = 1'b0;
    end
    @(posedge clk); #1;
    check_outputs("tick");
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
    cs = 1'b1; wr = 1'b1; rd = 1'b0; addr = a; wdata = d; be = b;
    tick();
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] a);
    cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = a;
    tick();
    cs = 1'b0; rd = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    #2 rst_n = 1'b1;
  endtask

  task automatic poll_done();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 32 && !seen; i++) begin
      do_read(4'd15);
      if (readdata === 32'h1) seen = 1'b1;
    end
    chk("poll_status_done", 128'(seen), 128'(1'b1));
  endtask

  task automatic load_key_ct(input logic [127:0] k, input logic [127:0] c);
    for (int i = 0; i < 4; i++) begin
      do_write(4'(i),     k[127-32*i -: 32], 4'hF);
      do_write(4'(i + 4), c[127-32*i -: 32], 4'hF);
    end
  endtask

  initial begin
    logic [3:0]   a;
    logic [127:0] k, c;
    model_reset();

    // reset state
    @(posedge clk); #1;
    check_outputs("reset");
    rst_n = 1'b1;

    // readback of every R/W register
    for (int i = 0; i < 14; i++) begin
      if (i >= 8 && i <= 11) continue;
      do_write(4'(i), 32'hDEADBEEF, 4'hF);
      do_read(4'(i));
      chk("deadbeef_rb", 128'(readdata), 128'(32'hDEADBEEF));
    end
    do_write(4'd8, 32'hDEADBEEF, 4'hF);
    do_read(4'd8);
    chk("ro_reg8", 128'(readdata), 128'(0));

    // mid-cycle async reset clears everything
    reset_pulse();

    // byte enables
    do_write(4'd12, 32'h11223344, 4'hF);
    do_write(4'd12, 32'hAABBCCDD, 4'b0101);
    do_read(4'd12);
    chk("byte_en", 128'(readdata), 128'(32'h11BB33DD));

    // random writes/reads, including read+write to the same address
    for (int n = 0; n < 40; n++) begin
      a = 4'($urandom_range(0, 15));
      if (a == 4'd14) a = 4'd13;
      do_write(a, $urandom, 4'($urandom_range(0, 15)));
      do_read(4'($urandom_range(0, 15)));
      if (n % 8 == 0) begin
        cs = 1'b1; rd = 1'b1; wr = 1'b1; addr = a; wdata = $urandom; be = 4'hF;
        tick();
        cs = 1'b0; rd = 1'b0; wr = 1'b0;
      end
    end

    // FIPS-197 decrypt, with a locked key write during RUN
    load_key_ct(FIPS_KEY, FIPS_CT);
    do_write(4'd14, 32'h1, 4'h1);
    do_write(4'd0, 32'h0, 4'hF);
    chk("lock_key", aes_key, FIPS_KEY);
    do_read(4'd15);
    chk("status_busy", 128'(readdata), 128'(32'h2));
    idle($urandom_range(1, 6));
    aes_done = 1'b1; msg_dec = FIPS_PT;
    poll_done();
    do_write(4'd14, 32'h1, 4'h1);
    for (int i = 0; i < 4; i++) begin
      do_read(4'(8 + i));
      chk("fips_pt", 128'(readdata), 128'(FIPS_PT[127-32*i -: 32]));
    end
    chk("fips_export", 128'(export_data), 128'(32'h69c4c55a));
    do_write(4'd14, 32'h0, 4'h1);
    aes_done = 1'b0;
    chk("stop_start_low", 128'(aes_start), 128'(0));
    do_read(4'd15);
    chk("status_keeps_done", 128'(readdata), 128'(32'h1));

    // abort: result discarded once the core finishes
    do_write(4'd14, 32'h1, 4'h1);
    idle(2);
    do_write(4'd14, 32'h0, 4'h1);
    do_write(4'd14, 32'h1, 4'h1);
    do_read(4'd15);
    chk("abort_status", 128'(readdata), 128'(32'h2));
    idle($urandom_range(0, 4));
    aes_done = 1'b1; msg_dec = {$urandom, $urandom, $urandom, $urandom};
    tick();
    aes_done = 1'b0;
    do_read(4'd15);
    chk("abort_idle", 128'(readdata), 128'(32'h0));
    do_read(4'd8);
    chk("abort_keep_pt", 128'(readdata), 128'(FIPS_PT[127:96]));

    // stop write in the same cycle as done
    do_write(4'd14, 32'h1, 4'h1);
    idle(2);
    aes_done = 1'b1; msg_dec = {$urandom, $urandom, $urandom, $urandom};
    do_write(4'd14, 32'h0, 4'h1);
    aes_done = 1'b0;
    do_read(4'd15);
    chk("simul_status", 128'(readdata), 128'(32'h0));
    do_read(4'd11);
    chk("simul_no_capture", 128'(readdata), 128'(FIPS_PT[31:0]));

    // reset during RUN, then a full random decrypt
    do_write(4'd14, 32'h1, 4'h1);
    idle(1);
    reset_pulse();
    chk("rst_run_start", 128'(aes_start), 128'(0));
    k = {$urandom, $urandom, $urandom, $urandom};
    c = {$urandom, $urandom, $urandom, $urandom};
    load_key_ct(k, c);
    do_write(4'd14, 32'h1, 4'h1);
    idle($urandom_range(1, 8));
    aes_done = 1'b1; msg_dec = k ^ c;
    poll_done();
    for (int i = 0; i < 4; i++) do_read(4'(8 + i));
    chk("rand_pt_word3", 128'(readdata), 128'((k ^ c) & 128'hFFFFFFFF));
    do_write(4'd14, 32'h0, 4'h1);
    aes_done = 1'b0;
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
